mips_inst_encoder: RTL
======================

Name: mips_inst_encoder

Overview:
- Inverse of the pipeline's opcode/funct control decoder: takes symbolic instruction requests (mnemonic index plus fields) and emits 32-bit MIPS words.
- Emitted words go out as an addressed write stream into instruction memory.
- Used by the bench/boot loader to build programs for the five-stage CPU.
- Runs a start/length burst with a valid/ready handshake on both sides and a one-word output register.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- CNT_W, 16, width of the burst length counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first byte address; low 2 bits ignored (treated as 0).
- length  in  CNT_W  number of words in the burst.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- op_sel  in  5  mnemonic index: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 SLT, 12 SLTU, 13 JR, 14 JALR, 15 LW, 16 SW, 17 LUI, 18 ADDI, 19 ADDIU, 20 ANDI, 21 SLTI, 22 SLTIU, 23 ORI, 24 BEQ, 25 BNE, 26 BLEZ, 27 BGTZ, 28 BLTZ, 29 J, 30 JAL, 31 NOP.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate / branch offset.
- target  in  26  jump target field.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory accepts the word.
- out_addr  out  ADDR_W  byte address of the word.
- out_word  out  32  encoded instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last word is accepted.
- fmt_err  out  1  sticky; cleared by start.

Behaviour:
- Reset values: all outputs 0; state IDLE; address and counters 0.
- States:
  - IDLE: start -> RUN (load addr = base_addr & ~3, remaining = length). If length == 0, go straight to DONE.
  - RUN: when remaining reaches 0 after the last acceptance -> FLUSH.
  - FLUSH: wait until the output register drains (out_valid && out_ready) -> DONE.
  - DONE: asserts done for one cycle -> IDLE.
- start while not IDLE is ignored.
- in_ready = (state == RUN) && (remaining != 0) && (!out_valid || out_ready).
- Input transfer: in_valid && in_ready.
  - The word is registered: out_word/out_addr update the next cycle, so latency is 1.
  - addr += 4 and remaining -= 1 on each transfer.
  - Sustained 1 word/cycle when out_ready is held high.
- Output: out_valid stays high, with out_word/out_addr stable, until out_ready. A simultaneous drain and new load replaces the register without a gap.
- Address wraps modulo 2^ADDR_W with no flag.
- Encoding, R-type {6'h00, rs, rt, rd, shamt, funct}:
  - funct: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLL 00, SRL 02, SRA 03, SLT 2a, SLTU 2b, JR 08, JALR 09.
  - Shifts force rs = 0.
  - JR forces rt = rd = 0.
  - JALR forces rt = 0.
  - shamt is forced 0 for every non-shift op; a nonzero input shamt sets fmt_err.
- Encoding, I-type {op, rs, rt, imm}:
  - op: LW 23, SW 2b, LUI 0f, ADDI 08, ADDIU 09, ANDI 0c, SLTI 0a, SLTIU 0b, ORI 0d, BEQ 04, BNE 05, BLEZ 06, BGTZ 07, BLTZ 01.
  - LUI forces rs = 0.
  - BLEZ, BGTZ and BLTZ force rt = 0.
- Encoding, J-type {op, target}: J 02, JAL 03.
- NOP encodes to 32'h0000_0000.
- Any forced-to-zero field that arrives nonzero sets fmt_err; the word is still emitted with that field zeroed.
- Reset mid-burst: immediate return to IDLE and out_valid drops; the partial burst is not resumed.

Optional Feature:
- Macro: MIPS_ENC_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], a running XOR of every word accepted by the output handshake.
  - Cleared on start and on reset; final value holds from done until the next start.
- Undefined: no checksum port or logic.

Test Plan:
- Reset, then start with base_addr=0x0000_1003, length=3, out_ready=1.
  - Requests: ADDU rs=8 rt=9 rd=10; LUI rt=1 imm=0x1234; JAL target=0x0100040.
  - Required words: 0x0109_5021 @0x1000, 0x3C01_1234 @0x1004, 0x0C10_0040 @0x1008.
  - done pulses exactly one cycle after the last output handshake.
- Backpressure: hold out_ready=0 for 4 cycles after the first word.
  - out_word/out_addr stay stable and in_ready=0.
  - Release gives back-to-back words with no loss or duplication.
- SLL rs=7 rt=2 rd=3 shamt=4 -> word 0x0002_1900, fmt_err=1. A following start clears fmt_err.
- length=0 start -> IDLE→DONE→IDLE, done pulses, no out_valid.
- Assert rst_n low while out_valid=1 mid-burst -> all outputs 0 asynchronously, state IDLE. A new start works normally.
- With MIPS_ENC_CHECKSUM_EN: burst of BEQ rs=1 rt=2 imm=0xFFFF then NOP -> checksum = 0x1022_FFFF.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: turns symbolic MIPS instruction requests into 32-bit
// words and streams them, with byte addresses, into instruction memory.
// Optional build macro MIPS_ENC_CHECKSUM_EN adds a running XOR checksum
// of every word accepted on the output side.
module mips_inst_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              busy,
    output logic              done,
    output logic              fmt_err
`ifdef MIPS_ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} encState_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_JR, OP_JALR, OP_LW,
        OP_SW, OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_ORI,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_J, OP_JAL, OP_NOP
    } mnem_e;

    encState_e         state;
    encState_e         stateNext;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic              startAcc;
    logic              xfer;
    logic              drain;

    logic        fmtR, fmtI, fmtJ;
    logic        zeroRs, zeroRt, zeroRd, keepShamt;
    logic [5:0]  funct, opcode;
    logic [4:0]  rsEff, rtEff, rdEff, shamtEff;
    logic [31:0] encWord;
    logic        encErr;

    assign startAcc = (state == S_IDLE) && start;
    assign in_ready = (state == S_RUN) && (remaining != '0) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // Decode the mnemonic into format, code and forced-zero fields, then build the word.
    always_comb begin
        fmtR      = 1'b0;
        fmtI      = 1'b0;
        fmtJ      = 1'b0;
        zeroRs    = 1'b0;
        zeroRt    = 1'b0;
        zeroRd    = 1'b0;
        keepShamt = 1'b0;
        funct     = '0;
        opcode    = '0;
        case (op_sel)
            OP_ADD:   begin fmtR = 1'b1; funct = 6'h20; end
            OP_ADDU:  begin fmtR = 1'b1; funct = 6'h21; end
            OP_SUB:   begin fmtR = 1'b1; funct = 6'h22; end
            OP_SUBU:  begin fmtR = 1'b1; funct = 6'h23; end
            OP_AND:   begin fmtR = 1'b1; funct = 6'h24; end
            OP_OR:    begin fmtR = 1'b1; funct = 6'h25; end
            OP_XOR:   begin fmtR = 1'b1; funct = 6'h26; end
            OP_NOR:   begin fmtR = 1'b1; funct = 6'h27; end
            OP_SLL:   begin fmtR = 1'b1; funct = 6'h00; zeroRs = 1'b1; keepShamt = 1'b1; end
            OP_SRL:   begin fmtR = 1'b1; funct = 6'h02; zeroRs = 1'b1; keepShamt = 1'b1; end
            OP_SRA:   begin fmtR = 1'b1; funct = 6'h03; zeroRs = 1'b1; keepShamt = 1'b1; end
            OP_SLT:   begin fmtR = 1'b1; funct = 6'h2a; end
            OP_SLTU:  begin fmtR = 1'b1; funct = 6'h2b; end
            OP_JR:    begin fmtR = 1'b1; funct = 6'h08; zeroRt = 1'b1; zeroRd = 1'b1; end
            OP_JALR:  begin fmtR = 1'b1; funct = 6'h09; zeroRt = 1'b1; end
            OP_LW:    begin fmtI = 1'b1; opcode = 6'h23; end
            OP_SW:    begin fmtI = 1'b1; opcode = 6'h2b; end
            OP_LUI:   begin fmtI = 1'b1; opcode = 6'h0f; zeroRs = 1'b1; end
            OP_ADDI:  begin fmtI = 1'b1; opcode = 6'h08; end
            OP_ADDIU: begin fmtI = 1'b1; opcode = 6'h09; end
            OP_ANDI:  begin fmtI = 1'b1; opcode = 6'h0c; end
            OP_SLTI:  begin fmtI = 1'b1; opcode = 6'h0a; end
            OP_SLTIU: begin fmtI = 1'b1; opcode = 6'h0b; end
            OP_ORI:   begin fmtI = 1'b1; opcode = 6'h0d; end
            OP_BEQ:   begin fmtI = 1'b1; opcode = 6'h04; end
            OP_BNE:   begin fmtI = 1'b1; opcode = 6'h05; end
            OP_BLEZ:  begin fmtI = 1'b1; opcode = 6'h06; zeroRt = 1'b1; end
            OP_BGTZ:  begin fmtI = 1'b1; opcode = 6'h07; zeroRt = 1'b1; end
            OP_BLTZ:  begin fmtI = 1'b1; opcode = 6'h01; zeroRt = 1'b1; end
            OP_J:     begin fmtJ = 1'b1; opcode = 6'h02; end
            OP_JAL:   begin fmtJ = 1'b1; opcode = 6'h03; end
            default:  ;
        endcase

        rsEff    = zeroRs ? '0 : rs;
        rtEff    = zeroRt ? '0 : rt;
        rdEff    = zeroRd ? '0 : rd;
        shamtEff = keepShamt ? shamt : '0;
        encWord  = '0;
        encErr   = 1'b0;
        if (fmtR) begin
            encWord = {6'h00, rsEff, rtEff, rdEff, shamtEff, funct};
            encErr  = (zeroRs && rs != '0) || (zeroRt && rt != '0) ||
                      (zeroRd && rd != '0) || (!keepShamt && shamt != '0);
        end else if (fmtI) begin
            encWord = {opcode, rsEff, rtEff, imm};
            encErr  = (zeroRs && rs != '0) || (zeroRt && rt != '0);
        end else if (fmtJ) begin
            encWord = {opcode, target};
        end
    end

    // Burst sequencing: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (start) stateNext = (length == '0) ? S_DONE : S_RUN;
            S_RUN:   if (xfer && remaining == CNT_W'(1)) stateNext = S_FLUSH;
            S_FLUSH: if (drain) stateNext = S_DONE;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= stateNext;
    end

    // Address/count tracking, one-word output register and sticky format error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_word  <= '0;
            fmt_err   <= 1'b0;
        end else begin
            if (startAcc) begin
                addr      <= base_addr & ~ADDR_W'(3);
                remaining <= length;
                fmt_err   <= 1'b0;
            end
            if (xfer) begin
                out_word  <= encWord;
                out_addr  <= addr;
                out_valid <= 1'b1;
                addr      <= addr + ADDR_W'(4);
                remaining <= remaining - CNT_W'(1);
                if (encErr) fmt_err <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MIPS_ENC_CHECKSUM_EN
    // Running XOR of accepted output words; holds after done until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum <= '0;
        else if (startAcc) checksum <= '0;
        else if (drain)    checksum <= checksum ^ out_word;
    end
`endif

endmodule
